// File: rtl/multichan_delay_pkg.sv
// Shared helpers for the multi-channel sample delay line: counter widths and delay clamping.
package mimo_delay_pkg;

    localparam int DEFAULT_MAX_DELAY = 16;

    // Width of a counter that must be able to hold max_delay itself.
    function automatic int dly_w(input int max_delay);
        return $clog2(max_delay + 1);
    endfunction

    function automatic int clamp_delay(input int sel, input int max_delay);
        return (sel > max_delay) ? max_delay : sel;
    endfunction

endpackage

// File: rtl/multichan_delay_if.sv
// Sample-stream bundle for multichan_delay: input strobe/data/control and delayed output/block markers.
interface multichan_delay_if #(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DELAY  = 16
);
    import mimo_delay_pkg::*;

    localparam int DLY_W = dly_w(MAX_DELAY);

    logic                         in_valid;
    logic [NUM_CH*DATA_WIDTH-1:0] in;
    logic [DLY_W-1:0]             delay_sel;
    logic                         flush;
    logic [NUM_CH*DATA_WIDTH-1:0] out;
    logic                         out_valid;
    logic                         block_toggle;
    logic                         block_last;

    modport master (
        output in_valid, in, delay_sel, flush,
        input  out, out_valid, block_toggle, block_last
    );

    modport slave (
        input  in_valid, in, delay_sel, flush,
        output out, out_valid, block_toggle, block_last
    );

endinterface

// File: rtl/multichan_delay_lane.sv
// One channel of the delay line: sample shift register advancing on shift_en_i, plus a tap mux
// returning the pre-shift sample tap_i positions back (tap_i==0 selects the incoming sample).
module delay_lane
    import mimo_delay_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_DELAY  = 16,
    localparam int DLY_W     = dly_w(MAX_DELAY)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  shift_en_i,
    input  logic                  clear_i,
    input  logic [DLY_W-1:0]      tap_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] tap_o
);

    logic [DATA_WIDTH-1:0] sr_q [MAX_DELAY];
    logic [DATA_WIDTH-1:0] sr_d [MAX_DELAY];

    // A clear coinciding with a shift still captures the new sample into sr[0].
    always_comb begin
        for (int i = 0; i < MAX_DELAY; i++) begin
            sr_d[i] = clear_i ? '0 : sr_q[i];
        end
        if (shift_en_i) begin
            sr_d[0] = din_i;
            for (int i = 1; i < MAX_DELAY; i++) begin
                sr_d[i] = clear_i ? '0 : sr_q[i-1];
            end
        end
    end

    always_comb begin
        tap_o = din_i;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (tap_i == DLY_W'(i + 1)) begin
                tap_o = sr_q[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

endmodule

// File: rtl/multichan_delay.sv
// Multi-channel sample delay line (delay counted in valid samples) with block toggle/last markers.
// Optional build macro MULTICHAN_DELAY_ZERO_FILL_EN: emit zeros during warm-up and clear lanes on flush.
module multichan_delay
    import mimo_delay_pkg::*;
#(
    parameter int MAX_DELAY  = 16,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CH     = 2,
    parameter int BLOCK_LEN  = 64
) (
    input  logic              clk,
    input  logic              reset,
    multichan_delay_if.slave  bus
);

    localparam int DLY_W = dly_w(MAX_DELAY);
    localparam int BLK_W = $clog2(BLOCK_LEN);
    localparam int BUS_W = NUM_CH * DATA_WIDTH;
    localparam logic [DLY_W-1:0] MAX_D    = DLY_W'(MAX_DELAY);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLOCK_LEN - 1);
`ifdef MULTICHAN_DELAY_ZERO_FILL_EN
    localparam bit ZERO_FILL = 1'b1;
`else
    localparam bit ZERO_FILL = 1'b0;
`endif

    logic             load_q, load_d;
    logic [DLY_W-1:0] active_q, active_d;
    logic [DLY_W-1:0] fill_q, fill_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic [BUS_W-1:0] out_q, out_d;
    logic             out_valid_q, out_valid_d;
    logic             toggle_q, toggle_d;
    logic             last_q, last_d;

    logic             load;
    logic [DLY_W-1:0] active_eff;
    logic [DLY_W-1:0] fill_eff;
    logic [BLK_W-1:0] blk_base;
    logic             primed;
    logic [BUS_W-1:0] tap_bus;

    // The first edge out of reset behaves like a flush so delay_sel is captured exactly once.
    assign load       = load_q | bus.flush;
    assign active_eff = load ? DLY_W'(clamp_delay(int'(bus.delay_sel), MAX_DELAY)) : active_q;
    assign fill_eff   = load ? '0 : fill_q;
    assign primed     = (fill_eff >= active_eff);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        delay_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .MAX_DELAY  (MAX_DELAY)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .shift_en_i (bus.in_valid),
            .clear_i    (ZERO_FILL && bus.flush),
            .tap_i      (active_eff),
            .din_i      (bus.in[c*DATA_WIDTH +: DATA_WIDTH]),
            .tap_o      (tap_bus[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    always_comb begin
        load_d      = 1'b0;
        active_d    = active_eff;
        fill_d      = fill_eff;
        blk_base    = load ? '0 : blk_q;
        blk_d       = blk_base;
        out_d       = out_q;
        out_valid_d = 1'b0;
        last_d      = 1'b0;
        toggle_d    = bus.flush ? 1'b0 : (toggle_q ^ last_q);

        if (bus.in_valid) begin
            fill_d      = (fill_eff == MAX_D) ? MAX_D : fill_eff + 1'b1;
            out_d       = (ZERO_FILL && !primed) ? '0 : tap_bus;
            out_valid_d = ZERO_FILL ? 1'b1 : primed;
        end

        if (out_valid_d) begin
            if (blk_base == BLK_LAST) begin
                blk_d  = '0;
                last_d = 1'b1;
            end else begin
                blk_d  = blk_base + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_q      <= 1'b1;
            active_q    <= '0;
            fill_q      <= '0;
            blk_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            toggle_q    <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            load_q      <= load_d;
            active_q    <= active_d;
            fill_q      <= fill_d;
            blk_q       <= blk_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            toggle_q    <= toggle_d;
            last_q      <= last_d;
        end
    end

    assign bus.out          = out_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.block_toggle = toggle_q;
    assign bus.block_last   = last_q;

endmodule

// File: tb/tb_multichan_delay.sv
// Bench for multichan_delay: vector table for the bubble pattern plus a sample-history scoreboard.
module tb_multichan_delay;

    localparam int MAXD = 16;
    localparam int BLK  = 4;
`ifdef MULTICHAN_DELAY_ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    multichan_delay_if #(.NUM_CH(2), .DATA_WIDTH(16), .MAX_DELAY(MAXD)) bus ();

    multichan_delay #(
        .MAX_DELAY  (MAXD),
        .DATA_WIDTH (16),
        .NUM_CH     (2),
        .BLOCK_LEN  (BLK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        ov;
        logic [31:0] out;
        logic        last;
        logic        tog;
    } exp_t;

    typedef struct {
        bit          v;
        logic [15:0] x;
        bit          ov;
        logic [15:0] out;
        bit          last;
    } vec_t;

    exp_t        sbq[$];
    vec_t        tbl[12];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state: every accepted sample since reset, and counts since the last restart.
    logic [15:0] hist0[$];
    logic [15:0] hist1[$];
    int          m_d = 0;
    int          m_nsince = 0;
    int          m_vcount = 0;
    bit          m_tog = 1'b0;
    bit          m_lastp = 1'b0;
    bit          m_init = 1'b1;
    logic [15:0] m_o0 = '0;
    logic [15:0] m_o1 = '0;
    logic [15:0] seq = 16'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        hist0.delete();
        hist1.delete();
        m_nsince = 0;
        m_vcount = 0;
        m_tog    = 1'b0;
        m_lastp  = 1'b0;
        m_init   = 1'b1;
        m_o0     = '0;
        m_o1     = '0;
        sbq.delete();
    endtask

    // Called at a falling edge: drives one cycle, predicts the registered result, checks it after the rising edge.
    task automatic cycle(input bit v, input logic [15:0] a, input logic [15:0] b,
                         input bit fl, input int dsel);
        exp_t e;
        bit   tn;
        int   total;
        bit   warm;
        bus.in_valid  = v;
        bus.in        = {b, a};
        bus.flush     = fl;
        bus.delay_sel = 5'(dsel);

        if (fl || m_init) begin
            m_d      = (dsel > MAXD) ? MAXD : dsel;
            m_nsince = 0;
            m_vcount = 0;
            tn       = 1'b0;
        end else begin
            tn = m_tog ^ m_lastp;
        end
        e.ov   = 1'b0;
        e.last = 1'b0;
        if (v) begin
            total = hist0.size();
            warm  = (m_nsince < m_d);
            if (m_d == 0) begin
                m_o0 = a;
                m_o1 = b;
            end else if (total >= m_d) begin
                m_o0 = hist0[total - m_d];
                m_o1 = hist1[total - m_d];
            end else begin
                m_o0 = '0;
                m_o1 = '0;
            end
            if (ZF && warm) begin
                m_o0 = '0;
                m_o1 = '0;
            end
            e.ov = ZF ? 1'b1 : !warm;
            hist0.push_back(a);
            hist1.push_back(b);
            m_nsince++;
        end
        if (e.ov) begin
            m_vcount++;
            e.last = (m_vcount % BLK == 0);
        end
        e.out = {m_o1, m_o0};
        e.tog = tn;
        sbq.push_back(e);
        m_tog   = tn;
        m_lastp = e.last;
        m_init  = 1'b0;

        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("out_valid", 32'(bus.out_valid), 32'(e.ov));
        chk("out", bus.out, e.out);
        chk("block_last", 32'(bus.block_last), 32'(e.last));
        chk("block_toggle", 32'(bus.block_toggle), 32'(e.tog));
        @(negedge clk);
    endtask

    task automatic sample(input bit v, input bit fl, input int dsel);
        if (v) seq = seq + 16'd1;
        cycle(v, v ? seq : 16'hDEAD, v ? (seq ^ 16'h5A00) : 16'hBEEF, fl, dsel);
    endtask

    task automatic run(input int n, input int dsel);
        for (int i = 0; i < n; i++) sample(1'b1, 1'b0, dsel);
    endtask

    initial begin
        // Bubble pattern at D=4: outputs follow sample count, not cycle count.
        tbl[0]  = '{1'b1, 16'd1, ZF, 16'd0, 1'b0};
        tbl[1]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        tbl[2]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        tbl[3]  = '{1'b1, 16'd2, ZF, 16'd0, 1'b0};
        tbl[4]  = '{1'b1, 16'd3, ZF, 16'd0, 1'b0};
        tbl[5]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        tbl[6]  = '{1'b1, 16'd4, ZF, 16'd0, ZF};
        tbl[7]  = '{1'b1, 16'd5, 1'b1, 16'd1, 1'b0};
        tbl[8]  = '{1'b1, 16'd6, 1'b1, 16'd2, 1'b0};
        tbl[9]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        tbl[10] = '{1'b1, 16'd7, 1'b1, 16'd3, 1'b0};
        tbl[11] = '{1'b1, 16'd8, 1'b1, 16'd4, 1'b1};

        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.flush     = 1'b0;
        bus.delay_sel = 5'd4;
        repeat (2) @(negedge clk);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset out", bus.out, 32'd0);
        chk("reset block_last", 32'(bus.block_last), 32'd0);
        chk("reset block_toggle", 32'(bus.block_toggle), 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            if (tbl[i].v) seq = tbl[i].x;
            cycle(tbl[i].v, tbl[i].v ? tbl[i].x : 16'hDEAD,
                  tbl[i].v ? (tbl[i].x ^ 16'h5A00) : 16'hBEEF, 1'b0, 4);
            // cycle() already advanced to the falling edge; outputs are stable there.
            chk($sformatf("tbl[%0d] out_valid", i), 32'(bus.out_valid), 32'(tbl[i].ov));
            chk($sformatf("tbl[%0d] block_last", i), 32'(bus.block_last), 32'(tbl[i].last));
            if (tbl[i].ov) chk($sformatf("tbl[%0d] out", i), 32'(bus.out[15:0]), 32'(tbl[i].out));
        end

        run(22, 4);
        // delay_sel changes without flush are ignored.
        run(4, 2);
        sample(1'b1, 1'b1, 2);
        run(10, 2);
        sample(1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) sample(i % 3 != 1, 1'b0, 0);
        sample(1'b1, 1'b1, 20);
        run(25, 20);
        sample(1'b0, 1'b1, 1);
        run(6, 1);
        sample(1'b1, 1'b1, 1);
        run(6, 1);
        sample(1'b0, 1'b1, 3);
        for (int i = 0; i < 9; i++) sample(i != 4, 1'b0, 3);

        for (int i = 0; i < 60; i++) begin
            bit fl;
            fl = ($urandom_range(0, 19) == 0);
            sample($urandom_range(0, 3) != 0, fl, int'($urandom_range(0, 20)));
        end

        // Asynchronous reset between edges while output is live.
        sample(1'b1, 1'b1, 0);
        run(5, 0);
        #2;
        reset = 1'b0;
        #1;
        chk("async out_valid", 32'(bus.out_valid), 32'd0);
        chk("async out", bus.out, 32'd0);
        chk("async block_last", 32'(bus.block_last), 32'd0);
        chk("async block_toggle", 32'(bus.block_toggle), 32'd0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        run(12, 3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multichan_delay.md
Name: multichan_delay

Overview:
Parametrised multi-channel sample delay line for the MIMO-OFDM datapath. It aligns NUM_CH antenna streams by a runtime-selectable delay counted in valid samples, not clock cycles. It advances only on in_valid, so it tolerates bubbles. It also emits a block toggle/last-sample marker every BLOCK_LEN valid outputs for downstream ping-pong buffers.

Parameters:
MAX_DELAY, 16, largest supported delay in samples (>=1)
DATA_WIDTH, 16, bits per channel sample
NUM_CH, 2, number of parallel channels sharing one valid/delay
BLOCK_LEN, 64, valid outputs per block for block_toggle/block_last (>=2)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (block in reset while 0)
in_valid  in  1  sample strobe; all channels are accepted together
in  in  NUM_CH*DATA_WIDTH  channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]
delay_sel  in  $clog2(MAX_DELAY+1)  requested delay D in samples; sampled only at reset release or on flush
flush  in  1  single-cycle restart: clears fill/block state and loads delay_sel
out  out  NUM_CH*DATA_WIDTH  delayed samples, same packing as in
out_valid  out  1  out holds a valid delayed sample this cycle
block_toggle  out  1  flips after every BLOCK_LEN valid outputs
block_last  out  1  asserted together with the BLOCK_LEN-th valid output of each block

Behaviour:
- Reset (reset=0, async): shift registers, out, out_valid, block_toggle, block_last, fill count and block count all go to 0. On the first clk edge with reset=1, active_delay <= min(delay_sel, MAX_DELAY).
- Per channel: shift register sr[0..MAX_DELAY-1]. sr[0] is the newest sample. It shifts only on in_valid=1.
- Output is registered. On an accepted sample x_n: out <= (active_delay==0) ? x_n : sr[active_delay-1] (pre-shift value, which is x_{n-D}). Result: out equals x_{n-D}, one clk after x_n is accepted.
- out_valid <= in_valid && (fill >= active_delay). It is 0 in any cycle after in_valid=0. out holds its value when no sample is accepted.
- fill counts accepted samples since reset/flush and saturates at MAX_DELAY; the counter width must hold MAX_DELAY.
- delay_sel > MAX_DELAY is clamped to MAX_DELAY. Changes to delay_sel without flush are ignored.
- flush=1: fill <= 0, block count <= 0, block_toggle <= 0, active_delay <= clamped delay_sel, and out_valid/block_last are 0 the next cycle. Shift-register data is kept, except under the optional feature.
- flush and in_valid in the same cycle: flush wins for state, and the sample is accepted as the first post-flush sample (fill becomes 1). Its output is produced only if the new D==0.
- Block count: increments on each cycle where out_valid is being set to 1. When it reaches BLOCK_LEN-1 at such an event, block_last <= 1 and the count wraps to 0. block_toggle flips on the cycle after block_last is high. block_last is a 1-cycle pulse.
- No backpressure: the downstream block must accept out every valid cycle.

Optional Feature:
MULTICHAN_DELAY_ZERO_FILL_EN
- Defined: out_valid <= in_valid from the first accepted sample. Outputs 0 for the first D samples, then x_{n-D}. flush also zeroes every shift register, so no stale data leaks.
- Undefined: behaviour exactly as above (warm-up samples suppressed, flush keeps data).

Decomposition:
- Package mimo_delay_pkg: localparam helpers for counter widths (DLY_W = $clog2(MAX_DELAY+1)) and function clamp_delay.
- Sub-module delay_lane (DATA_WIDTH, MAX_DELAY): one channel's shift register plus tap mux, with shift enable, zero-clear and tap-select inputs. Instantiate it NUM_CH times in a generate loop.
- Top level owns fill counter, active_delay, valid and block logic.

Test Plan:
- Reset release, D=4, continuous in_valid, ch0 = 1,2,3,... -> out_valid first high 1 clk after 5th sample, ch0 out=1; thereafter out = n-4.
- D=4, in_valid pattern 1,0,0,1,1,0,1... -> delay is counted in samples: out sequence identical to the continuous case, out_valid high only 1 clk after accepted samples.
- D=0 -> out = in registered by one clk, out_valid = in_valid delayed 1; D=20 with MAX_DELAY=16 -> behaves as D=16.
- After 30 samples at D=4, set delay_sel=2 and pulse flush together with in_valid -> next out_valid 0; output resumes after 3rd post-flush sample with 2-sample delay; delay_sel changes without flush have no effect.
- BLOCK_LEN=4, continuous valid -> block_last on valid outputs 4,8,12; block_toggle 0->1->0 one clk after each block_last; flush mid-block restarts the count at 0.
- Async reset asserted mid-stream between edges -> all outputs 0 immediately. With MULTICHAN_DELAY_ZERO_FILL_EN, D=3 -> out_valid from the 1st sample, out = 0,0,0,1,2,...
